// File: rtl/pc_stack.sv
// Program counter with edge/level stepping, absolute load, signed relative branch
// and call/return through a small internal return-address stack.
module pc_stack #(
    parameter int SIZE       = 8,
    parameter int OFF_W      = 4,
    parameter int DEPTH      = 4,
    parameter int EDGE_STEP  = 1,
    parameter int RESET_ADDR = 0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       step,
    input  logic                       load,
    input  logic                       call,
    input  logic                       ret,
    input  logic                       rel,
    input  logic [SIZE-1:0]            target,
    input  logic [OFF_W-1:0]           rel_off,
    output logic [SIZE-1:0]            out,
    output logic [$clog2(DEPTH+1)-1:0] depth,
    output logic                       stack_full,
    output logic                       stack_empty,
    output logic                       wrap,
    output logic                       err
);
    localparam int DW = $clog2(DEPTH + 1);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [SIZE-1:0] out_reg, out_next;
    logic [DW-1:0]   depth_reg, depth_next, depth_dec;
    logic            err_reg, err_next;
    logic            wrap_reg, wrap_next;
    logic            step_prev_reg;
    logic            step_fire;
    logic            push;
    logic [SIZE-1:0] stack_mem [DEPTH];
    logic [AW-1:0]   push_idx, pop_idx;
    logic [SIZE-1:0] rel_ext, inc_val;
    logic [SIZE:0]   rel_sum;
    logic            rel_wrap;

    assign step_fire = step & ((EDGE_STEP == 0) ? 1'b1 : ~step_prev_reg);

    assign depth_dec = depth_reg - DW'(1);
    assign push_idx  = depth_reg[AW-1:0];
    assign pop_idx   = depth_dec[AW-1:0];
    assign inc_val   = out_reg + SIZE'(1);
    assign rel_ext   = SIZE'($signed(rel_off));
    assign rel_sum   = {1'b0, out_reg} + {1'b0, rel_ext};
    // A negative offset stays in range only if the unsigned add carries out.
    assign rel_wrap  = rel_off[OFF_W-1] ? ~rel_sum[SIZE] : rel_sum[SIZE];

    always_comb begin
        out_next   = out_reg;
        depth_next = depth_reg;
        err_next   = err_reg;
        wrap_next  = 1'b0;
        push       = 1'b0;
        if (load) begin
            out_next = target;
        end else if (call) begin
            if (depth_reg == DW'(DEPTH)) begin
                err_next = 1'b1;
            end else begin
                push       = 1'b1;
                depth_next = depth_reg + DW'(1);
                out_next   = target;
            end
        end else if (ret) begin
            if (depth_reg == '0) begin
                err_next = 1'b1;
            end else begin
                out_next   = stack_mem[pop_idx];
                depth_next = depth_dec;
            end
        end else if (rel) begin
            out_next  = rel_sum[SIZE-1:0];
            wrap_next = rel_wrap;
        end else if (step_fire) begin
            out_next  = inc_val;
            wrap_next = &out_reg;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_reg       <= SIZE'(RESET_ADDR);
            depth_reg     <= '0;
            err_reg       <= 1'b0;
            wrap_reg      <= 1'b0;
            step_prev_reg <= 1'b0;
        end else begin
            out_reg       <= out_next;
            depth_reg     <= depth_next;
            err_reg       <= err_next;
            wrap_reg      <= wrap_next;
            step_prev_reg <= step;
        end
    end

    // Stack contents need no reset; depth alone defines which entries are valid.
    always_ff @(posedge clk) begin
        if (push) begin
            stack_mem[push_idx] <= inc_val;
        end
    end

    assign out         = out_reg;
    assign depth       = depth_reg;
    assign err         = err_reg;
    assign wrap        = wrap_reg;
    assign stack_full  = (depth_reg == DW'(DEPTH));
    assign stack_empty = (depth_reg == '0);
endmodule

// File: tb/tb_pc_stack.sv
// Bench for pc_stack: edge-step and level-step instances share stimulus and are
// checked every cycle against a behavioural model, plus directed literal checks.
module tb_pc_stack;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       step = 1'b0, load = 1'b0, call = 1'b0, ret = 1'b0, rel = 1'b0;
    logic [7:0] target = '0;
    logic [3:0] rel_off = '0;

    logic [7:0] out_e, out_l;
    logic [2:0] depth_e, depth_l;
    logic       full_e, full_l, empty_e, empty_l, wrap_e, wrap_l, err_e, err_l;

    always #5 clk = ~clk;

    pc_stack #(.SIZE(8), .OFF_W(4), .DEPTH(4), .EDGE_STEP(1), .RESET_ADDR(0)) dut_e (
        .clk(clk), .reset(reset), .step(step), .load(load), .call(call), .ret(ret),
        .rel(rel), .target(target), .rel_off(rel_off), .out(out_e), .depth(depth_e),
        .stack_full(full_e), .stack_empty(empty_e), .wrap(wrap_e), .err(err_e)
    );

    pc_stack #(.SIZE(8), .OFF_W(4), .DEPTH(4), .EDGE_STEP(0), .RESET_ADDR(0)) dut_l (
        .clk(clk), .reset(reset), .step(step), .load(load), .call(call), .ret(ret),
        .rel(rel), .target(target), .rel_off(rel_off), .out(out_l), .depth(depth_l),
        .stack_full(full_l), .stack_empty(empty_l), .wrap(wrap_l), .err(err_l)
    );

    int n_chk  = 0;
    int n_pass = 0;
    bit chk_on = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Behavioural model: index 0 = edge-step instance, index 1 = level-step instance.
    int m_out [2];
    int m_dep [2];
    int m_stk [2][4];
    bit m_err [2];
    bit m_wrap[2];
    bit m_prev;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < 2; k++) begin
                m_out[k] = 0; m_dep[k] = 0; m_err[k] = 0; m_wrap[k] = 0;
            end
            m_prev = 0;
        end else begin
            int off;
            off = rel_off[3] ? int'(rel_off) - 16 : int'(rel_off);
            for (int k = 0; k < 2; k++) begin
                bit fire;
                int t;
                fire = (k == 0) ? (step && !m_prev) : step;
                m_wrap[k] = 0;
                if (load) begin
                    m_out[k] = int'(target);
                end else if (call) begin
                    if (m_dep[k] == 4) m_err[k] = 1;
                    else begin
                        m_stk[k][m_dep[k]] = (m_out[k] + 1) % 256;
                        m_dep[k]++;
                        m_out[k] = int'(target);
                    end
                end else if (ret) begin
                    if (m_dep[k] == 0) m_err[k] = 1;
                    else begin
                        m_dep[k]--;
                        m_out[k] = m_stk[k][m_dep[k]];
                    end
                end else if (rel) begin
                    t = m_out[k] + off;
                    m_wrap[k] = (t < 0) || (t > 255);
                    m_out[k] = (t + 256) % 256;
                end else if (fire) begin
                    t = m_out[k] + 1;
                    m_wrap[k] = (t > 255);
                    m_out[k] = t % 256;
                end
            end
            m_prev = step;
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            chk("out_e", out_e, m_out[0]);     chk("out_l", out_l, m_out[1]);
            chk("depth_e", depth_e, m_dep[0]); chk("depth_l", depth_l, m_dep[1]);
            chk("full_e", full_e, m_dep[0] == 4);  chk("full_l", full_l, m_dep[1] == 4);
            chk("empty_e", empty_e, m_dep[0] == 0); chk("empty_l", empty_l, m_dep[1] == 0);
            chk("wrap_e", wrap_e, m_wrap[0]);  chk("wrap_l", wrap_l, m_wrap[1]);
            chk("err_e", err_e, m_err[0]);     chk("err_l", err_l, m_err[1]);
        end
    end

    task automatic drive(input bit s, input bit l, input bit c, input bit r, input bit rl,
                         input logic [7:0] tg, input logic [3:0] ro);
        @(negedge clk);
        step = s; load = l; call = c; ret = r; rel = rl; target = tg; rel_off = ro;
        $display("t=%0t step=%0b load=%0b call=%0b ret=%0b rel=%0b target=%02h rel_off=%0h out_e=%02h out_l=%02h depth=%0d",
                 $time, s, l, c, r, rl, tg, ro, out_e, out_l, depth_e);
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 8'h00, 4'h0);
    endtask

    initial begin
        @(negedge clk);
        @(negedge clk);
        chk("rst_out", out_e, 32'h0);
        chk("rst_empty", empty_e, 32'h1);
        chk("rst_err", err_e, 32'h0);
        reset  = 1'b0;
        chk_on = 1'b1;

        // Held step: edge instance moves once, level instance every cycle.
        repeat (5) drive(1, 0, 0, 0, 0, 8'h00, 4'h0);
        idle();
        chk("edge_hold", out_e, 32'h01);
        chk("level_hold", out_l, 32'h05);
        repeat (3) begin
            drive(1, 0, 0, 0, 0, 8'h00, 4'h0);
            idle();
        end
        chk("edge_pulses", out_e, 32'h04);

        // Level stepping across the top of the address space.
        drive(0, 1, 0, 0, 0, 8'hFE, 4'h0);
        drive(1, 0, 0, 0, 0, 8'h00, 4'h0);
        chk("lvl_fe", out_l, 32'hFE);
        drive(1, 0, 0, 0, 0, 8'h00, 4'h0);
        chk("lvl_ff", out_l, 32'hFF);
        chk("lvl_ff_wrap", wrap_l, 32'h0);
        drive(1, 0, 0, 0, 0, 8'h00, 4'h0);
        chk("lvl_00", out_l, 32'h00);
        chk("lvl_00_wrap", wrap_l, 32'h1);
        idle();
        chk("lvl_01", out_l, 32'h01);
        chk("lvl_01_wrap", wrap_l, 32'h0);

        // Relative branches, including wrap in both directions.
        drive(0, 1, 0, 0, 0, 8'h10, 4'h0);
        drive(0, 0, 0, 0, 1, 8'h00, 4'hC);
        idle();
        chk("rel_neg", out_e, 32'h0C);
        chk("rel_neg_wrap", wrap_e, 32'h0);
        drive(0, 1, 0, 0, 0, 8'h02, 4'h0);
        drive(0, 0, 0, 0, 1, 8'h00, 4'hC);
        idle();
        chk("rel_under", out_e, 32'hFE);
        chk("rel_under_wrap", wrap_e, 32'h1);
        idle();
        chk("wrap_pulse", wrap_e, 32'h0);
        drive(0, 1, 0, 0, 0, 8'hFE, 4'h0);
        drive(0, 0, 0, 0, 1, 8'h00, 4'h3);
        idle();
        chk("rel_over", out_e, 32'h01);
        chk("rel_over_wrap", wrap_e, 32'h1);

        // Call/return and return-on-empty error.
        drive(0, 1, 0, 0, 0, 8'h05, 4'h0);
        drive(0, 0, 1, 0, 0, 8'h40, 4'h0);
        drive(0, 0, 1, 0, 0, 8'h80, 4'h0);
        drive(0, 0, 0, 1, 0, 8'h00, 4'h0);
        chk("call2_out", out_e, 32'h80);
        chk("call2_depth", depth_e, 32'h2);
        drive(0, 0, 0, 1, 0, 8'h00, 4'h0);
        chk("ret1", out_e, 32'h41);
        drive(0, 0, 0, 1, 0, 8'h00, 4'h0);
        chk("ret2", out_e, 32'h06);
        chk("ret2_empty", empty_e, 32'h1);
        idle();
        chk("ret3_out", out_e, 32'h06);
        chk("ret3_err", err_e, 32'h1);
        drive(0, 1, 0, 0, 0, 8'h20, 4'h0);
        idle();
        chk("err_sticky", err_e, 32'h1);
        chk("err_load", out_e, 32'h20);

        // Call from FF pushes 00 without a wrap pulse.
        drive(0, 1, 0, 0, 0, 8'hFF, 4'h0);
        drive(0, 0, 1, 0, 0, 8'h10, 4'h0);
        idle();
        chk("call_ff_wrap", wrap_e, 32'h0);
        drive(0, 0, 0, 1, 0, 8'h00, 4'h0);
        idle();
        chk("ret_ff_out", out_e, 32'h00);
        chk("ret_ff_wrap", wrap_e, 32'h0);

        // Asynchronous reset between edges, just after a call has taken effect.
        @(negedge clk);
        call = 1'b1; target = 8'h33;
        @(posedge clk);
        #2;
        chk("pre_rst_out", out_e, 32'h33);
        chk("pre_rst_depth", depth_e, 32'h1);
        reset = 1'b1;
        #1;
        chk("arst_out", out_e, 32'h00);
        chk("arst_depth", depth_e, 32'h0);
        chk("arst_err", err_e, 32'h0);
        chk("arst_err_l", err_l, 32'h0);
        @(negedge clk);
        reset = 1'b0; call = 1'b0; step = 1'b1;
        repeat (3) drive(1, 0, 0, 0, 0, 8'h00, 4'h0);
        idle();
        chk("post_rst_edge", out_e, 32'h01);
        chk("post_rst_level", out_l, 32'h04);

        // Fill the stack, overflow, then a three-way priority collision.
        drive(0, 0, 1, 0, 0, 8'hA0, 4'h0);
        drive(0, 0, 1, 0, 0, 8'hA1, 4'h0);
        drive(0, 0, 1, 0, 0, 8'hA2, 4'h0);
        drive(0, 0, 1, 0, 0, 8'hA3, 4'h0);
        drive(0, 0, 1, 0, 0, 8'hA4, 4'h0);
        chk("full_depth", depth_e, 32'h4);
        chk("full_flag", full_e, 32'h1);
        chk("full_err0", err_e, 32'h0);
        idle();
        chk("ovf_out", out_e, 32'hA3);
        chk("ovf_err", err_e, 32'h1);
        chk("ovf_depth", depth_e, 32'h4);
        drive(1, 1, 1, 0, 0, 8'h77, 4'h0);
        idle();
        chk("prio_out", out_e, 32'h77);
        chk("prio_depth", depth_e, 32'h4);
        repeat (4) drive(0, 0, 0, 1, 0, 8'h00, 4'h0);
        idle();
        chk("unwind_out", out_e, 32'h02);
        chk("unwind_empty", empty_e, 32'h1);
        idle();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/pc_stack.md
Name: pc_stack

Overview:
- Parametrised program counter for the sequencer datapath; next generation of the single-increment PC.
- Adds edge- or level-triggered stepping, absolute load, signed relative branch, and call/return via an internal return-address stack.
- Drives instruction-memory address; status flags feed the control FSM and debug.

Parameters:
SIZE, 8, address width in bits (>=2)
OFF_W, 4, width of signed relative-branch offset (2..SIZE)
DEPTH, 4, return-stack entries (>=1)
EDGE_STEP, 1, 1 = step acts on rising edge of step input only; 0 = step acts every cycle it is high
RESET_ADDR, 0, value loaded into out on reset

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  asynchronous, active-high reset
step  input  1  increment request
load  input  1  absolute jump to target
call  input  1  push return address, jump to target
ret  input  1  pop return address into PC
rel  input  1  relative branch by rel_off
target  input  SIZE  destination for load/call
rel_off  input  OFF_W  signed two's-complement offset for rel
out  output  SIZE  current program counter
depth  output  $clog2(DEPTH+1)  number of valid stack entries
stack_full  output  1  depth == DEPTH
stack_empty  output  1  depth == 0
wrap  output  1  one-cycle pulse: last PC update crossed 2^SIZE-1 -> 0 or 0 -> 2^SIZE-1
err  output  1  sticky error flag

Behaviour:
- Reset (async, any time, mid-operation included): out=RESET_ADDR, depth=0, stack contents don't-care, wrap=0, err=0, step-edge history register=0. First post-reset cycle with step high counts as a rising edge.
- All commands are sampled on the rising clk edge; the result is visible on out in the following cycle (1-cycle latency).
- Exactly one command acts per cycle. Priority: load > call > ret > rel > step. Lower-priority requests in the same cycle are ignored, not queued.
- step_fire = step & ~step_prev when EDGE_STEP=1; step_fire = step when EDGE_STEP=0. step_prev is registered every cycle regardless of which command won.
- load: out <= target; stack unchanged.
- call with depth<DEPTH: stack[depth] <= out+1 (mod 2^SIZE); depth++; out <= target.
- call with depth==DEPTH: no push, out unchanged, err <= 1.
- ret with depth>0: out <= stack[depth-1]; depth--.
- ret with depth==0: out unchanged, err <= 1.
- rel: out <= out + sign_extend(rel_off), computed in SIZE bits and modulo 2^SIZE.
- step_fire: out <= out + 1, modulo 2^SIZE.
- No command: out holds.
- wrap is registered. It is 1 for the cycle after a step or rel update whose true (unwrapped) result fell outside 0..2^SIZE-1; otherwise 0.
- load, call and ret never assert wrap. A call pushing out+1 that wraps to 0 is legal and does not assert wrap.
- err is sticky; only reset clears it.
- stack_full and stack_empty are combinational from depth.

Test Plan:
- Reset, SIZE=8, EDGE_STEP=1: hold step high for 5 cycles -> out goes 0 to 1 once and stays 1. Pulse step 3 more times -> out=4.
- EDGE_STEP=0, out=8'hFE: step high for 3 cycles -> out sequence FF, 00, 01; wrap=1 only in the cycle out=00.
- out=8'h10: rel with rel_off=4'b1100 (-4) -> out=0C. From out=02, rel_off=-4 -> out=FE, wrap=1.
- out=8'h05: call target=40, then call target=80 -> out=80, depth=2. Two rets -> out=41, then 06; stack_empty=1. A third ret -> out stays 06, err=1, and err stays 1 through later valid commands.
- DEPTH=4: five calls -> depth=4, stack_full=1; fifth call leaves out at the 4th target and sets err. load, call and step asserted in the same cycle -> load wins, depth unchanged.
- Assert reset asynchronously, between clock edges, during a call -> out=RESET_ADDR, depth=0, err=0 immediately. After release, a held step yields exactly one increment.
